// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus front-end.
package lsu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NBYTES-1:0] be_t;

  // Size field 11 and the 11x encodings have no legal access width.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// Replicates store data onto the byte lanes selected by the address offset and
// flags halfword/word accesses that straddle their natural alignment.
module store_lane_aligner
  import lsu_pkg::*;
(
  input  logic [2:0]       func3,
  input  logic [OFF_W-1:0] off,
  input  word_t            wdata,
  output word_t            lane_wdata,
  output be_t              lane_be,
  output logic             misaligned
);

  // NOTE: every output gets a default first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    lane_wdata = wdata;
    lane_be    = '1;
    misaligned = 1'b0;
    case (func3[1:0])
      2'b00: begin
        lane_wdata = {NBYTES{wdata[7:0]}};
        lane_be    = be_t'(1) << off;
      end
      2'b01: begin
        lane_wdata = {(NBYTES/2){wdata[15:0]}};
        lane_be    = off[1] ? be_t'(4'b1100) : be_t'(4'b0011);
        misaligned = off[0];
      end
      2'b10: begin
        misaligned = (off != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_interface.sv
// Single-outstanding load/store front-end: registers one core request, drives a
// req/gnt/rvalid bus handshake with timeout, and returns the raw read word.
module lsu_bus_interface
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int NUM_BYTES      = NBYTES,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [2:0]                   req_func3,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         busy,
  output logic                         resp_valid,
  output logic                         resp_err,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic [$clog2(NUM_BYTES)-1:0] resp_byte_off,
  output logic [2:0]                   resp_func3,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [NUM_BYTES-1:0]         mem_be,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e             state;
  logic [TO_W-1:0]        tmo_cnt;
  logic [OFF_W-1:0]       cur_off;
  logic [2:0]             cur_func3;

  word_t                  al_wdata;
  be_t                    al_be;
  logic                   al_misaligned;
  logic                   accept, illegal, gnt_now, done_ok, done_tmo;

  store_lane_aligner u_aligner (
    .func3      (req_func3),
    .off        (req_addr[OFF_W-1:0]),
    .wdata      (req_wdata),
    .lane_wdata (al_wdata),
    .lane_be    (al_be),
    .misaligned (al_misaligned)
  );

  assign accept   = req_valid & req_ready;
  assign illegal  = f3_illegal(req_func3) | al_misaligned;
  assign gnt_now  = (state == REQ) & mem_gnt;
  // A grant and read data in the same REQ cycle complete the access directly.
  assign done_ok  = ((state == WAIT) | gnt_now) & mem_rvalid;
  assign done_tmo = (tmo_cnt == TO_LAST) &
                    (((state == REQ) & ~mem_gnt) | ((state == WAIT) & ~mem_rvalid));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      cur_off       <= '0;
      cur_func3     <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      resp_byte_off <= '0;
      resp_func3    <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_ready <= 1'b0;
          if (illegal) begin
            state         <= ERR;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_rdata    <= '0;
            resp_byte_off <= req_addr[OFF_W-1:0];
            resp_func3    <= req_func3;
          end else begin
            state     <= REQ;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
            cur_off   <= req_addr[OFF_W-1:0];
            cur_func3 <= req_func3;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata <= req_we ? al_wdata : '0;
            mem_be    <= req_we ? al_be : '1;
          end
        end
        REQ, WAIT: begin
          if (gnt_now) mem_req <= 1'b0;
          if (done_ok) begin
            state         <= RESP;
            busy          <= 1'b0;
            mem_req       <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b0;
            resp_rdata    <= mem_we ? '0 : mem_rdata;
            resp_byte_off <= cur_off;
            resp_func3    <= cur_func3;
          end else if (done_tmo) begin
            state         <= ERR;
            busy          <= 1'b0;
            mem_req       <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_rdata    <= '0;
            resp_byte_off <= cur_off;
            resp_func3    <= cur_func3;
          end else if (gnt_now) begin
            state   <= WAIT;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_interface.sv
// Directed bench for lsu_bus_interface with a short bus timeout.
module tb_lsu_bus_interface;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_byte_off;
  logic [2:0]  resp_func3;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .resp_byte_off(resp_byte_off), .resp_func3(resp_func3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; on return the DUT is in the cycle after accept.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_be", mem_be, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // lw 0x100, gnt at N+1, rvalid at N+2, response at N+3
    issue(1'b0, F3_W, 32'h100, 32'h0);
    check("lw_mem_req", mem_req, 1);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_be", mem_be, 4'b1111);
    check("lw_wdata", mem_wdata, 0);
    check("lw_busy", busy, 1);
    check("lw_ready", req_ready, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    check("lw_wait_req", mem_req, 0);
    check("lw_wait_resp", resp_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    check("lw_resp_valid", resp_valid, 1);
    check("lw_rdata", resp_rdata, 32'hDEADBEEF);
    check("lw_err", resp_err, 0);
    check("lw_func3", resp_func3, 3'b010);
    check("lw_busy_done", busy, 0);
    tick();
    check("lw_resp_pulse", resp_valid, 0);
    check("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);
    check("lw_ready_back", req_ready, 1);

    // sb 0x103 with gnt and rvalid together
    issue(1'b1, F3_B, 32'h103, 32'h000000A5);
    check("sb_be", mem_be, 4'b1000);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_addr", mem_addr, 32'h100);
    check("sb_we", mem_we, 1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("sb_resp_valid", resp_valid, 1);
    check("sb_rdata_zero", resp_rdata, 0);
    check("sb_off", resp_byte_off, 3);
    check("sb_func3", resp_func3, 3'b000);
    tick();

    // misaligned lh 0x101: error response the cycle after accept, no bus request
    issue(1'b0, F3_H, 32'h101, 32'h0);
    check("lh_mis_valid", resp_valid, 1);
    check("lh_mis_err", resp_err, 1);
    check("lh_mis_mem_req", mem_req, 0);
    check("lh_mis_off", resp_byte_off, 1);
    check("lh_mis_rdata", resp_rdata, 0);
    check("lh_mis_busy", busy, 0);
    tick();
    check("lh_mis_ready", req_ready, 1);

    // lbu 0x102 with grant withheld for 3 cycles
    issue(1'b0, F3_BU, 32'h102, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("lbu_req_held", mem_req, 1);
      check("lbu_addr_held", mem_addr, 32'h100);
      tick();
    end
    check("lbu_req_4th", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_rvalid = 1'b0;
    check("lbu_resp_valid", resp_valid, 1);
    check("lbu_err", resp_err, 0);
    check("lbu_rdata", resp_rdata, 32'h11223344);
    check("lbu_off", resp_byte_off, 2);
    check("lbu_func3", resp_func3, 3'b100);
    tick();

    // sh 0x102 lands on the upper halfword lanes
    issue(1'b1, F3_H, 32'h102, 32'h0000BEEF);
    check("sh_be", mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("sh_resp", resp_valid, 1);
    tick();

    // illegal func3 011
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    check("f3_ill_err", resp_err, 1);
    check("f3_ill_valid", resp_valid, 1);
    tick();

    // grant never arrives: error after 4 REQ cycles, late rvalid ignored
    issue(1'b0, F3_W, 32'h200, 32'h0);
    tick(); tick(); tick();
    check("tmo_req_4th", mem_req, 1);
    check("tmo_no_resp", resp_valid, 0);
    tick();
    check("tmo_valid", resp_valid, 1);
    check("tmo_err", resp_err, 1);
    check("tmo_mem_req", mem_req, 0);
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("tmo_stray", resp_valid, 0);
    check("tmo_ready", req_ready, 1);

    // reset while waiting for read data
    issue(1'b0, F3_W, 32'h300, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rstw_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_addr", mem_addr, 0);
    check("rstw_resp", resp_valid, 0);
    check("rstw_ready", req_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    issue(1'b0, F3_W, 32'h304, 32'h0);
    check("rstw_lw_addr", mem_addr, 32'h304);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    check("rstw_lw_valid", resp_valid, 1);
    check("rstw_lw_rdata", resp_rdata, 32'hCAFEF00D);
    tick();

    // back-to-back: req_valid held, second request waits for IDLE
    req_valid = 1'b1; req_we = 1'b0; req_func3 = F3_W; req_addr = 32'h400;
    tick();
    req_addr = 32'h404;
    check("b2b_ready_busy", req_ready, 0);
    check("b2b_addr1", mem_addr, 32'h400);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0001;
    check("b2b_addr1_wait", mem_addr, 32'h400);
    tick();
    mem_rvalid = 1'b0;
    check("b2b_resp1", resp_valid, 1);
    check("b2b_rdata1", resp_rdata, 32'hAAAA0001);
    check("b2b_ready_resp", req_ready, 0);
    tick();
    check("b2b_ready_idle", req_ready, 1);
    check("b2b_idle_resp", resp_valid, 0);
    tick();
    req_valid = 1'b0;
    check("b2b_req2", mem_req, 1);
    check("b2b_addr2", mem_addr, 32'h404);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBBBB0002;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("b2b_resp2", resp_valid, 1);
    check("b2b_rdata2", resp_rdata, 32'hBBBB0002);
    tick();
    check("b2b_end", resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
